// File: rtl/slot_sched_pkg.sv
// Shared types and helpers for the time-slot round-robin scheduler.
package slot_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shortest legal slot; a requested length of 0 is raised to this.
  localparam int unsigned K_MIN = 1;

  function automatic int unsigned clamp_k(input int unsigned k);
    return (k < K_MIN) ? K_MIN : k;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr (mod R).
module rr_pick #(
  parameter int R = 4
) (
  input  logic [R-1:0]         i_req,
  input  logic [$clog2(R)-1:0] i_ptr,
  output logic                 o_valid,
  output logic [$clog2(R)-1:0] o_idx
);

  localparam int W = $clog2(R);
  localparam logic [W:0] R_W = (W+1)'(R);

  logic [2*R-1:0] dbl;
  logic [R-1:0]   rot;
  logic [W-1:0]   hit;
  logic [W:0]     sum;

  // Rotate so that bit 0 of rot is the requester at i_ptr.
  assign dbl = {i_req, i_req} >> i_ptr;
  assign rot = dbl[R-1:0];

  // Lowest set bit of the rotated vector, then map back to an absolute index.
  always_comb begin
    o_valid = 1'b0;
    hit     = '0;
    for (int j = R - 1; j >= 0; j--) begin
      if (rot[j]) begin
        o_valid = 1'b1;
        hit     = W'(j);
      end
    end
    sum = {1'b0, i_ptr} + {1'b0, hit};
    if (sum >= R_W) begin
      sum = sum - R_W;
    end
    o_idx = sum[W-1:0];
  end

endmodule

// File: rtl/slot_scheduler.sv
// Time-slot round-robin scheduler: each winner holds a one-hot grant for
// exactly k_active cycles; the slot length is only changed at slot entry.
module slot_scheduler
  import slot_sched_pkg::*;
#(
  parameter int N         = 4,
  parameter int R         = 4,
  parameter int K_DEFAULT = 4
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_enable,
  input  logic [N-1:0]         i_k,
  input  logic                 i_k_valid,
  input  logic [R-1:0]         i_req,
  output logic [R-1:0]         o_grant,
  output logic [$clog2(R)-1:0] o_grant_idx,
  output logic                 o_slot_start,
  output logic                 o_roll_over,
  output logic                 o_busy
);

  localparam int W = $clog2(R);

  state_t       state_q, state_d;
  logic [N-1:0] count_q, count_d;
  logic [N-1:0] k_active_q, k_active_d;
  logic [N-1:0] k_pending_q, k_pending_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;

  logic [N-1:0] k_in;
  logic [W-1:0] next_ptr;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick_idx;
  logic         pick_valid;
  logic         roll;
  logic         start;

  assign k_in     = N'(clamp_k(32'(i_k)));
  assign next_ptr = (idx_q == W'(R - 1)) ? '0 : idx_q + 1'b1;
  // At roll-over the picker must already see the advanced pointer.
  assign pick_ptr = (state_q == RUN) ? next_ptr : ptr_q;
  assign roll     = (state_q == RUN) && (count_q == k_active_q - 1'b1);
  assign start    = i_enable && pick_valid;

  rr_pick #(.R(R)) u_pick (
    .i_req   (i_req),
    .i_ptr   (pick_ptr),
    .o_valid (pick_valid),
    .o_idx   (pick_idx)
  );

  // State registers; reset clears everything so outputs drop immediately.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      k_active_q  <= N'(K_DEFAULT);
      k_pending_q <= N'(K_DEFAULT);
      ptr_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      k_active_q  <= k_active_d;
      k_pending_q <= k_pending_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
    end
  end

  // Next-state logic: slot entry latches the pick and the pending length
  // (including a strobe arriving in the same cycle).
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    k_active_d  = k_active_q;
    k_pending_d = i_k_valid ? k_in : k_pending_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          count_d    = '0;
          idx_d      = pick_idx;
          k_active_d = k_pending_d;
        end
      end
      RUN: begin
        if (roll) begin
          ptr_d   = next_ptr;
          count_d = '0;
          if (start) begin
            idx_d      = pick_idx;
            k_active_d = k_pending_d;
          end else begin
            state_d = IDLE;
            idx_d   = '0;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy       = (state_q == RUN);
  assign o_grant      = o_busy ? (R'(1) << idx_q) : '0;
  assign o_grant_idx  = idx_q;
  assign o_slot_start = o_busy && (count_q == '0);
  assign o_roll_over  = roll;

endmodule

// File: tb/tb_slot_scheduler.sv
// Scoreboard bench for slot_scheduler: stimulus pushes expected slots
// (grant, index, length); a monitor pops one per completed slot.
module tb_slot_scheduler;

  localparam int N = 4;
  localparam int R = 4;
  localparam int KD = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         kv = 1'b0;
  logic [N-1:0] k = '0;
  logic [R-1:0] req = '0;
  logic [R-1:0] grant;
  logic [1:0]   gidx;
  logic         ss, ro, busy;

  typedef struct packed {
    logic [R-1:0] grant;
    logic [1:0]   idx;
    logic [7:0]   len;
  } slot_t;

  slot_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  slot_scheduler #(.N(N), .R(R), .K_DEFAULT(KD)) dut (
    .i_clk        (clk),
    .i_reset      (rst_n),
    .i_enable     (en),
    .i_k          (k),
    .i_k_valid    (kv),
    .i_req        (req),
    .o_grant      (grant),
    .o_grant_idx  (gidx),
    .o_slot_start (ss),
    .o_roll_over  (ro),
    .o_busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s actual=%h required=%h", name, act, want);
    end else begin
      $display("ok   %s value=%h", name, act);
    end
  endtask

  task automatic push(input logic [R-1:0] g, input logic [1:0] i, input int len);
    slot_t e;
    e.grant = g;
    e.idx   = i;
    e.len   = 8'(len);
    exp_q.push_back(e);
  endtask

  task automatic wait_starts(input int n);
    int seen = 0;
    for (int c = 0; c < 200 && seen < n; c++) begin
      @(negedge clk);
      if (ss) seen++;
    end
    if (seen < n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_slot_start seen=%0d required=%0d", seen, n);
    end
  endtask

  task automatic drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 200) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    @(negedge clk);
    check("idle_after", {23'd0, grant, gidx, ss, ro, busy}, 32'd0);
  endtask

  // Monitor: one scoreboard comparison per completed slot.
  initial begin : monitor
    logic [R-1:0] g0;
    logic [1:0]   i0;
    int           len;
    slot_t        e;
    g0  = '0;
    i0  = '0;
    len = 0;
    forever begin
      @(negedge clk);
      if (ss) begin
        g0  = grant;
        i0  = gidx;
        len = 1;
      end else if (busy) begin
        len++;
      end
      if (ro) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_slot grant=%b idx=%0d len=%0d required=no slot", grant, gidx, len);
        end else begin
          e = exp_q.pop_front();
          if (g0 !== e.grant || grant !== e.grant || i0 !== e.idx ||
              gidx !== e.idx || len != int'(e.len)) begin
            miscompares++;
            $display("FAIL slot grant=%b/%b idx=%0d/%0d len=%0d required grant=%b idx=%0d len=%0d",
                     g0, grant, i0, gidx, len, e.grant, e.idx, e.len);
          end else begin
            $display("slot grant=%b idx=%0d len=%0d", grant, gidx, len);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    // Reset and idle behaviour
    repeat (2) @(negedge clk);
    check("in_reset", {23'd0, grant, gidx, ss, ro, busy}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("idle_no_req", {23'd0, grant, gidx, ss, ro, busy}, 32'd0);
    end

    // Sole requester wins back-to-back, 4-cycle slots
    push(4'b0010, 2'd1, 4); push(4'b0010, 2'd1, 4); push(4'b0010, 2'd1, 4);
    req = 4'b0010;
    wait_starts(3);
    req = 4'b0000;
    drain();

    // Pointer now 2: 1010 alternates 3,1,3
    push(4'b1000, 2'd3, 4); push(4'b0010, 2'd1, 4); push(4'b1000, 2'd3, 4);
    req = 4'b1010;
    wait_starts(3);
    req = 4'b0000;
    drain();

    // Pointer now 0: full rotation
    push(4'b0001, 2'd0, 4); push(4'b0010, 2'd1, 4); push(4'b0100, 2'd2, 4);
    push(4'b1000, 2'd3, 4); push(4'b0001, 2'd0, 4);
    req = 4'b1111;
    wait_starts(5);
    req = 4'b0000;
    drain();

    // k=2 strobed mid-slot, then k=0 clamped to 1 (pointer now 1)
    push(4'b0010, 2'd1, 4); push(4'b0100, 2'd2, 2); push(4'b1000, 2'd3, 2);
    push(4'b0001, 2'd0, 1); push(4'b0010, 2'd1, 1);
    req = 4'b1111;
    wait_starts(1);
    @(negedge clk);
    @(negedge clk);
    k  = 4'd2;
    kv = 1'b1;
    @(negedge clk);
    kv = 1'b0;
    wait_starts(2);
    k  = 4'd0;
    kv = 1'b1;
    @(negedge clk);
    kv = 1'b0;
    wait_starts(2);
    req = 4'b0000;
    drain();

    // Strobe coinciding with an IDLE start applies to that slot (pointer 2)
    push(4'b0100, 2'd2, 3);
    req = 4'b0100;
    k   = 4'd3;
    kv  = 1'b1;
    @(negedge clk);
    kv  = 1'b0;
    req = 4'b0000;
    drain();

    // Strobe in a roll-over cycle applies to the next slot (pointer 3)
    push(4'b1000, 2'd3, 3); push(4'b0001, 2'd0, 5);
    req = 4'b1001;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    k  = 4'd5;
    kv = 1'b1;
    @(negedge clk);
    kv  = 1'b0;
    req = 4'b0000;
    drain();

    // Asynchronous reset in the middle of a slot
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset", {31'd0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", {23'd0, grant, gidx, ss, ro, busy}, 32'd0);
    req = 4'b0000;
    en  = 1'b0;
    @(negedge clk);
    check("held_reset", {23'd0, grant, gidx, ss, ro, busy}, 32'd0);
    rst_n = 1'b1;

    // Non-preemption: enable drops in slot cycle 1 (pointer 0, k=4)
    push(4'b0001, 2'd0, 4);
    req = 4'b1111;
    en  = 1'b1;
    wait_starts(1);
    @(negedge clk);
    en = 1'b0;
    drain();

    // Non-preemption: owner's request drops in slot cycle 1 (pointer 1)
    push(4'b0010, 2'd1, 4); push(4'b0100, 2'd2, 4);
    en = 1'b1;
    wait_starts(1);
    @(negedge clk);
    req = 4'b1101;
    wait_starts(1);
    req = 4'b0000;
    drain();

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
